// File: rtl/cw_bus_arbiter_if.sv
// cw_bus_arbiter_if: master request/response ports and CW bus pad signals.
// The arbiter uses the master modport; masters, slave and pads see the slave modport.
interface cw_bus_arbiter_if;
    logic        m0_req, m1_req;
    logic        m0_we, m1_we;
    logic [15:0] m0_adr, m1_adr;
    logic [15:0] m0_wdat, m1_wdat;
    logic        m0_ack, m1_ack;
    logic        m0_err, m1_err;
    logic [15:0] m0_rdat, m1_rdat;
    logic [15:0] cw_io_i, cw_io_o;
    logic        cw_req, cw_dir;
    logic        cw_ack, cw_err;

    modport master (
        input  m0_req, m1_req, m0_we, m1_we, m0_adr, m1_adr, m0_wdat, m1_wdat,
        input  cw_io_i, cw_ack, cw_err,
        output m0_ack, m1_ack, m0_err, m1_err, m0_rdat, m1_rdat,
        output cw_io_o, cw_req, cw_dir
    );

    modport slave (
        output m0_req, m1_req, m0_we, m1_we, m0_adr, m1_adr, m0_wdat, m1_wdat,
        output cw_io_i, cw_ack, cw_err,
        input  m0_ack, m1_ack, m0_err, m1_err, m0_rdat, m1_rdat,
        input  cw_io_o, cw_req, cw_dir
    );
endinterface

// File: rtl/cw_bus_arbiter.sv
// cw_bus_arbiter: round-robin two-master arbiter and sequencer for the 16-bit CW bus.
// Define CW_ARB_TIMEOUT_EN to add a WAIT timeout of 2^TIMEOUT_W-1 cycles.
module cw_bus_arbiter #(
    parameter int TIMEOUT_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    cw_bus_arbiter_if.master   bus,
    output logic               o_busy,
    output logic               o_owner
);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, WAIT, RESP} state_t;

    state_t      r_state, w_nxt;
    logic        r_last, r_owner, r_we, r_busy;
    logic [15:0] r_wdat;
    logic        r_cw_req, r_cw_dir;
    logic [15:0] r_cw_io;
    logic        r_m0_ack, r_m0_err, r_m1_ack, r_m1_err;
    logic [15:0] r_m0_rdat, r_m1_rdat;
    logic        w_take, w_gnt, w_we, w_fin, w_ok, w_tmo;
    logic [15:0] w_adr;

    assign w_gnt  = (bus.m0_req & bus.m1_req) ? ~r_last : bus.m1_req;
    assign w_take = (r_state == IDLE) & (bus.m0_req | bus.m1_req);
    assign w_we   = w_take ? (w_gnt ? bus.m1_we : bus.m0_we) : r_we;
    assign w_adr  = w_gnt ? bus.m1_adr : bus.m0_adr;
    // err outranks ack; a bare timeout also lands here as an error
    assign w_ok   = bus.cw_ack & ~bus.cw_err;
    assign w_fin  = (r_state == WAIT) & (w_nxt == RESP);

`ifdef CW_ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_cnt;
    // Fires in the last allowed WAIT cycle, the one whose increment would reach all-ones
    assign w_tmo = (r_state == WAIT) & (r_cnt == {{(TIMEOUT_W-1){1'b1}}, 1'b0});
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_cnt <= '0;
        else       r_cnt <= (r_state == WAIT) ? r_cnt + 1'b1 : '0;
    end
`else
    assign w_tmo = 1'b0;
`endif

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE:    w_nxt = (bus.m0_req | bus.m1_req) ? ADDR : IDLE;
            ADDR:    w_nxt = r_we ? DATA : WAIT;
            DATA:    w_nxt = WAIT;
            WAIT:    w_nxt = (bus.cw_ack | bus.cw_err | w_tmo) ? RESP : WAIT;
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_last    <= 1'b1;
            r_owner   <= 1'b0;
            r_we      <= 1'b0;
            r_wdat    <= '0;
            r_busy    <= 1'b0;
            r_cw_req  <= 1'b0;
            r_cw_dir  <= 1'b0;
            r_cw_io   <= '0;
            r_m0_ack  <= 1'b0;
            r_m0_err  <= 1'b0;
            r_m1_ack  <= 1'b0;
            r_m1_err  <= 1'b0;
            r_m0_rdat <= '0;
            r_m1_rdat <= '0;
        end else begin
            r_state  <= w_nxt;
            r_busy   <= w_nxt != IDLE;
            r_cw_req <= (w_nxt == ADDR) | (w_nxt == DATA);
            r_cw_dir <= ((w_nxt == ADDR) | (w_nxt == WAIT)) ? w_we : (w_nxt == DATA);
            r_cw_io  <= (w_nxt == ADDR) ? w_adr :
                        ((w_nxt == DATA) | ((w_nxt == WAIT) & r_we)) ? r_wdat : '0;
            if (w_take) begin
                r_owner <= w_gnt;
                r_we    <= w_we;
                r_wdat  <= w_gnt ? bus.m1_wdat : bus.m0_wdat;
            end
            if (r_state == RESP) r_last <= r_owner;
            r_m0_ack <= w_fin & w_ok & ~r_owner;
            r_m0_err <= w_fin & ~w_ok & ~r_owner;
            r_m1_ack <= w_fin & w_ok & r_owner;
            r_m1_err <= w_fin & ~w_ok & r_owner;
            if (w_fin & w_ok & ~r_we & ~r_owner) r_m0_rdat <= bus.cw_io_i;
            if (w_fin & w_ok & ~r_we & r_owner)  r_m1_rdat <= bus.cw_io_i;
        end
    end

    assign bus.cw_req  = r_cw_req;
    assign bus.cw_dir  = r_cw_dir;
    assign bus.cw_io_o = r_cw_io;
    assign bus.m0_ack  = r_m0_ack;
    assign bus.m0_err  = r_m0_err;
    assign bus.m1_ack  = r_m1_ack;
    assign bus.m1_err  = r_m1_err;
    assign bus.m0_rdat = r_m0_rdat;
    assign bus.m1_rdat = r_m1_rdat;
    assign o_busy      = r_busy;
    assign o_owner     = r_owner;
endmodule

// File: tb/tb_cw_bus_arbiter.sv
// tb_cw_bus_arbiter: per-cycle vector table plus directed reset, round-robin and timeout sequences.
module tb_cw_bus_arbiter;
    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    logic o_busy, o_owner;
    int   checks = 0;
    int   errors = 0;

    cw_bus_arbiter_if bus();

    cw_bus_arbiter #(.TIMEOUT_W(4)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .bus     (bus),
        .o_busy  (o_busy),
        .o_owner (o_owner)
    );

    always #5 i_clk = ~i_clk;

    // ctl = {m0_req, m1_req, we, cw_ack, cw_err}; fl = {cw_req, cw_dir, m0_ack, m0_err, m1_ack, m1_err, busy, owner}
    typedef struct {
        logic [4:0]  ctl;
        logic [15:0] adr, wdat, io_i;
        logic [7:0]  fl;
        logic [15:0] io_o, rd0, rd1;
    } vec_t;

    vec_t vt [22];

    function automatic logic [55:0] snap();
        return {bus.cw_req, bus.cw_dir, bus.m0_ack, bus.m0_err, bus.m1_ack, bus.m1_err,
                o_busy, o_owner, bus.cw_io_o, bus.m0_rdat, bus.m1_rdat};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        int n, pulses;
        logic got;
        logic [3:0] ord;
        bus.m0_req = 0; bus.m1_req = 0; bus.m0_we = 0; bus.m1_we = 0;
        bus.m0_adr = 0; bus.m1_adr = 0; bus.m0_wdat = 0; bus.m1_wdat = 0;
        bus.cw_io_i = 0; bus.cw_ack = 0; bus.cw_err = 0;

        vt[0]  = '{5'b10000, 16'h1234, 16'h0000, 16'h0000, 8'b10000010, 16'h1234, 16'h0000, 16'h0000};
        vt[1]  = '{5'b10000, 16'h1234, 16'h0000, 16'h0000, 8'b00000010, 16'h0000, 16'h0000, 16'h0000};
        vt[2]  = '{5'b10010, 16'h1234, 16'h0000, 16'hBEEF, 8'b00100010, 16'h0000, 16'hBEEF, 16'h0000};
        vt[3]  = '{5'b00000, 16'h0000, 16'h0000, 16'h0000, 8'b00000000, 16'h0000, 16'hBEEF, 16'h0000};
        vt[4]  = '{5'b01100, 16'h0010, 16'hA5A5, 16'h0000, 8'b11000011, 16'h0010, 16'hBEEF, 16'h0000};
        vt[5]  = '{5'b01100, 16'h0010, 16'hA5A5, 16'h0000, 8'b11000011, 16'hA5A5, 16'hBEEF, 16'h0000};
        vt[6]  = '{5'b01100, 16'h0010, 16'hA5A5, 16'h0000, 8'b01000011, 16'hA5A5, 16'hBEEF, 16'h0000};
        vt[7]  = '{5'b01100, 16'h0010, 16'hA5A5, 16'h0000, 8'b01000011, 16'hA5A5, 16'hBEEF, 16'h0000};
        vt[8]  = '{5'b01110, 16'h0010, 16'hA5A5, 16'h1111, 8'b00001011, 16'h0000, 16'hBEEF, 16'h0000};
        vt[9]  = '{5'b00000, 16'h0000, 16'h0000, 16'h0000, 8'b00000001, 16'h0000, 16'hBEEF, 16'h0000};
        vt[10] = '{5'b10000, 16'h0042, 16'h0000, 16'h0000, 8'b10000010, 16'h0042, 16'hBEEF, 16'h0000};
        vt[11] = '{5'b10011, 16'h0042, 16'h0000, 16'h0000, 8'b00000010, 16'h0000, 16'hBEEF, 16'h0000};
        vt[12] = '{5'b10011, 16'h0042, 16'h0000, 16'hDEAD, 8'b00010010, 16'h0000, 16'hBEEF, 16'h0000};
        vt[13] = '{5'b00000, 16'h0000, 16'h0000, 16'h0000, 8'b00000000, 16'h0000, 16'hBEEF, 16'h0000};
        vt[14] = '{5'b01000, 16'h8001, 16'h0000, 16'h0000, 8'b10000011, 16'h8001, 16'hBEEF, 16'h0000};
        vt[15] = '{5'b01000, 16'h8001, 16'h0000, 16'h0000, 8'b00000011, 16'h0000, 16'hBEEF, 16'h0000};
        vt[16] = '{5'b01001, 16'h8001, 16'h0000, 16'h5555, 8'b00000111, 16'h0000, 16'hBEEF, 16'h0000};
        vt[17] = '{5'b01000, 16'h7777, 16'h0000, 16'h0000, 8'b00000001, 16'h0000, 16'hBEEF, 16'h0000};
        vt[18] = '{5'b01000, 16'h7777, 16'h0000, 16'h0000, 8'b10000011, 16'h7777, 16'hBEEF, 16'h0000};
        vt[19] = '{5'b01000, 16'h7777, 16'h0000, 16'h0000, 8'b00000011, 16'h0000, 16'hBEEF, 16'h0000};
        vt[20] = '{5'b01010, 16'h7777, 16'h0000, 16'hC0DE, 8'b00001011, 16'h0000, 16'hBEEF, 16'hC0DE};
        vt[21] = '{5'b00000, 16'h0000, 16'h0000, 16'h0000, 8'b00000001, 16'h0000, 16'hBEEF, 16'hC0DE};

        #2 chk("reset_state", 64'(snap()), 64'd0);
        #10 i_rst = 0;

        // Each vector: inputs held for one cycle, outputs checked just after the closing edge
        for (int i = 0; i < 22; i++) begin
            bus.m0_req  = vt[i].ctl[4];
            bus.m1_req  = vt[i].ctl[3];
            bus.m0_we   = vt[i].ctl[2];
            bus.m1_we   = vt[i].ctl[2];
            bus.cw_ack  = vt[i].ctl[1];
            bus.cw_err  = vt[i].ctl[0];
            bus.m0_adr  = vt[i].ctl[4] ? vt[i].adr : ~vt[i].adr;
            bus.m1_adr  = vt[i].ctl[3] ? vt[i].adr : ~vt[i].adr;
            bus.m0_wdat = vt[i].ctl[4] ? vt[i].wdat : ~vt[i].wdat;
            bus.m1_wdat = vt[i].ctl[3] ? vt[i].wdat : ~vt[i].wdat;
            bus.cw_io_i = vt[i].io_i;
            @(posedge i_clk); #1;
            chk($sformatf("vec%0d", i), 64'(snap()),
                64'({vt[i].fl, vt[i].io_o, vt[i].rd0, vt[i].rd1}));
        end

        // Reset asserted during the DATA beat of an m1 write
        bus.m0_req = 0; bus.m1_req = 1; bus.m1_we = 1;
        bus.m1_adr = 16'h0300; bus.m1_wdat = 16'h3333;
        bus.cw_ack = 0; bus.cw_err = 0;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        chk("rst_pre_data", {bus.cw_req, bus.cw_dir, bus.cw_io_o}, {2'b11, 16'h3333});
        #2 i_rst = 1;
        #1 chk("rst_async_drop", {bus.cw_req, bus.cw_dir, o_busy}, 3'b000);
        bus.cw_ack = 1;
        pulses = 0;
        repeat (2) begin
            @(posedge i_clk); #1;
            pulses += int'(bus.m0_ack | bus.m0_err | bus.m1_ack | bus.m1_err);
        end
        i_rst = 0;
        chk("rst_no_resp", pulses, 0);
        n = 0; got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(posedge i_clk); #1;
            n++;
            if (bus.m1_ack) got = 1;
        end
        chk("rst_recover_ack", got, 1);
        chk("rst_recover_latency", n, 4);
        bus.m1_req = 0; bus.cw_ack = 0;
        @(posedge i_clk); #1;
        chk("rst_recover_idle", o_busy, 0);

        // Both masters request continuously from reset
        i_rst = 1; #1 i_rst = 0;
        bus.m0_req = 1; bus.m1_req = 1; bus.m0_we = 0; bus.m1_we = 0;
        bus.m0_adr = 16'h1000; bus.m1_adr = 16'h2000;
        bus.cw_ack = 1; bus.cw_io_i = 16'h4242;
        n = 0; ord = 4'b0000;
        for (int k = 0; k < 40 && n < 4; k++) begin
            @(posedge i_clk); #1;
            if (bus.m0_ack | bus.m1_ack) begin
                ord[n] = bus.m1_ack;
                n++;
            end
        end
        bus.m0_req = 0; bus.m1_req = 0; bus.cw_ack = 0;
        chk("rr_count", n, 4);
        chk("rr_order", ord, 4'b1010);
        chk("rr_rdat", {bus.m0_rdat, bus.m1_rdat}, {16'h4242, 16'h4242});
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        chk("rr_idle", o_busy, 0);

        // m0 read with no slave response
        bus.m0_req = 1; bus.m0_we = 0; bus.m0_adr = 16'h0BAD;
        @(posedge i_clk); #1;
        chk("tmo_addr", {bus.cw_req, bus.cw_io_o}, {1'b1, 16'h0BAD});
        n = 0; got = 0;
`ifdef CW_ARB_TIMEOUT_EN
        for (int k = 0; k < 100 && !got; k++) begin
            @(posedge i_clk); #1;
            if (bus.m0_err) got = 1;
            else n++;
        end
        bus.m0_req = 0;
        chk("tmo_err", got, 1);
        chk("tmo_wait_cycles", n, 15);
        chk("tmo_no_ack", bus.m0_ack, 0);
        @(posedge i_clk); #1;
        chk("tmo_idle", o_busy, 0);
`else
        pulses = 0;
        repeat (1000) begin
            @(posedge i_clk); #1;
            pulses += int'(bus.m0_ack | bus.m0_err);
        end
        chk("no_tmo_pulses", pulses, 0);
        chk("no_tmo_still_wait", {o_busy, bus.cw_req}, 2'b10);
        bus.cw_ack = 1;
        @(posedge i_clk); #1;
        bus.cw_ack = 0; bus.m0_req = 0;
        chk("no_tmo_late_ack", {bus.m0_ack, bus.m0_err}, 2'b10);
        @(posedge i_clk); #1;
        chk("no_tmo_idle", o_busy, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cw_bus_arbiter.md
# cw_bus_arbiter

Two-master arbiter and transaction sequencer for the shared external 16-bit CW bus (`cw_io`, `cw_req`, `cw_dir`, `cw_ack`, `cw_err`). It sits between the core's bus master (m0) and the debug/LA master (m1) and the CW pads. It grants the bus round-robin, drives the address and data beats, waits for the slave response with an optional timeout, and returns the response to the owning master.

## Interface
- `TIMEOUT_W`, default 8: width of the WAIT timeout counter. Timeout fires after 2^TIMEOUT_W-1 WAIT cycles.
- `i_clk` in 1: the single clock.
- `i_rst` in 1: asynchronous, active-high reset.
- `m0_req`, `m1_req` in 1: request. Held with payload stable until that master's ack or err.
- `m0_we`, `m1_we` in 1: 1 = write, 0 = read.
- `m0_adr`, `m1_adr` in 16: address.
- `m0_wdat`, `m1_wdat` in 16: write data.
- `m0_ack`, `m1_ack` out 1: one-cycle success pulse.
- `m0_err`, `m1_err` out 1: one-cycle error pulse.
- `m0_rdat`, `m1_rdat` out 16: read data. Valid in the ack cycle and held until that master's next ack.
- `cw_io_i` in 16: bus data from pads.
- `cw_io_o` out 16: bus data to pads.
- `cw_req` out 1: beat strobe.
- `cw_dir` out 1: 1 = arbiter drives the bus (write). Feeds pad OEB logic.
- `cw_ack`, `cw_err` in 1: slave response, already synchronous to `i_clk`.
- `o_busy` out 1: high in every state except IDLE.
- `o_owner` out 1: current or last granted master.

## Operation
- All outputs are registered.
- FSM states: IDLE, ADDR, DATA, WAIT, RESP.
- **IDLE**
  - No request: stay in IDLE.
  - Exactly one request: grant that master.
  - Both requesting: grant the master not in `last`.
  - On grant: latch we/adr/wdat and owner, then go to ADDR.
- **ADDR**
  - `cw_req`=1, `cw_dir`=we, `cw_io_o`=adr.
  - Next state: DATA if we, else WAIT.
- **DATA**
  - `cw_req`=1, `cw_dir`=1, `cw_io_o`=wdat.
  - Next state: WAIT.
- **WAIT**
  - `cw_req`=0. `cw_dir` holds we. `cw_io_o` holds wdat for a write, 0 for a read.
  - `cw_err`=1: go to RESP with error.
  - Else `cw_ack`=1: go to RESP with ok. For a read, capture `cw_io_i` into owner's rdat.
  - Ack and err in the same cycle: err wins.
  - `cw_ack`/`cw_err` are ignored outside WAIT.
- **RESP**
  - One cycle: owner's ack or err =1, `cw_dir`=0.
  - `last` <= owner.
  - Next state: IDLE.
- The non-owner's ack/err/rdat are never disturbed.
- Masters must drop or replace `req` on the edge that samples their ack/err. The arbiter re-samples requests in IDLE the next cycle.
- A master deasserting `req` mid-transaction has no effect: the transaction completes and the response is still pulsed.

## Timing
- Reset values:
  - State IDLE, `last`=1, so m0 wins the first tie.
  - All ack/err/`cw_req`/`cw_dir`/`o_busy`/`o_owner` = 0.
  - `cw_io_o`=0, rdat=0, timeout counter=0.
- Reset mid-transaction: immediate abort. `cw_req`/`cw_dir` drop asynchronously and no response pulse is issued.
- Read, `req` sampled at cycle 0 (IDLE):
  - ADDR at cycle 1.
  - WAIT from cycle 2.
  - If ack arrives in cycle 2, ack pulses in cycle 3 (minimum 3 cycles).
- Write: one extra cycle for DATA; minimum 4 cycles.
- Back-to-back: a new grant is possible in the IDLE cycle right after RESP. The minimum gap between transactions is 1 idle cycle.
- Round-robin fairness:
  - With both requesting continuously, grants alternate m0, m1, m0, …
  - Each master waits at most one other transaction.

## Configuration
- Macro `CW_ARB_TIMEOUT_EN`.
- Defined:
  - A TIMEOUT_W-bit counter clears on entry to WAIT and increments each WAIT cycle without a response.
  - When it reaches 2^TIMEOUT_W-1 with no response, the FSM goes to RESP with error.
  - A response in the same cycle as expiry takes priority over the timeout.
- Undefined:
  - No counter is instantiated and WAIT lasts indefinitely.
  - `TIMEOUT_W` is unused.

## Test plan
- m0 read adr 0x1234, `cw_ack` with `cw_io_i`=0xBEEF in the first WAIT cycle:
  - `cw_io_o`=0x1234 with `cw_req`=1, `cw_dir`=0 in cycle 1.
  - `m0_ack`=1 and `m0_rdat`=0xBEEF in cycle 3.
- m1 write adr 0x0010, data 0xA5A5, ack after 2 WAIT cycles:
  - Beats 0x0010 then 0xA5A5 with `cw_dir`=1.
  - `m1_ack` pulses in cycle 5.
  - `m0` outputs stay 0.
- m0 and m1 request together from reset, both re-requesting immediately:
  - Grant order m0, m1, m0, m1 over 4 transactions.
- `cw_ack` and `cw_err` both high in WAIT: owner sees err=1, ack=0, and rdat is unchanged.
- With `CW_ARB_TIMEOUT_EN`, `TIMEOUT_W`=4, no response:
  - err pulses after 15 WAIT cycles and the FSM returns to IDLE.
  - Without the macro, the FSM is still in WAIT after 1000 cycles.
- `i_rst` asserted during DATA:
  - `cw_req`=0 and `o_busy`=0 immediately, no ack/err pulse.
  - After release, the next m1 request is served normally.
